dpe_route_lookup: RTL and testbench

- Lookup client stage directly upstream of the DPE routing memory (TCAM + action RAM).
- Accepts per-packet header descriptors (destination IPv4 address, ingress port, packet tag) over a valid/ready stream.
- Presents the registered destination IP to the routing memory's combinational lookup port and captures the hit, route index, destination port, peer and bypass result into a registered output stream.
- Provides a freeze/ack handshake so software can rewrite table entries with no lookup in flight.

---
 rtl/dpe_pkg.sv | 18 +
 rtl/dpe_route_lookup_if.sv | 38 +++
 rtl/dpe_skid_reg.sv | 28 ++
 rtl/dpe_route_lookup.sv | 103 ++++++++++
 tb/tb_dpe_route_lookup.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/dpe_pkg.sv
// dpe_pkg: shared DPE widths, route-result struct, freeze FSM states and a saturating-increment helper
package dpe_pkg;
  localparam int DPE_PORT_W = 3;
  localparam int DPE_PEER_W = 8;
  localparam int DPE_ROUTE_IDX_W = 6;
  typedef enum logic [1:0] {RUN, DRAIN, FROZEN} frz_state_e;
  typedef struct packed {
    logic                       hit;
    logic [DPE_ROUTE_IDX_W-1:0] idx;
    logic [DPE_PORT_W-1:0]      dst;
    logic [DPE_PEER_W-1:0]      peer;
    logic                       bypass;
    logic                       hairpin;
  } route_res_t;
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return &v ? v : v + 32'd1;
  endfunction
endpackage

// File: rtl/dpe_route_lookup_if.sv
// dpe_route_lookup_if: descriptor input stream, routing-memory lookup port and result output stream; slave = lookup stage, master = environment
interface dpe_route_lookup_if import dpe_pkg::*; #(parameter int ROUTE_IDX_W = 6, parameter int TAG_W = 8);
  logic                   in_valid;
  logic                   in_ready;
  logic [31:0]            in_dst_ip;
  logic [DPE_PORT_W-1:0]  in_ingress;
  logic [TAG_W-1:0]       in_tag;
  logic [31:0]            lk_req_ip;
  logic                   lk_req_valid;
  logic                   lk_hit;
  logic [ROUTE_IDX_W-1:0] lk_route_idx;
  logic [DPE_PORT_W-1:0]  lk_dst;
  logic [DPE_PEER_W-1:0]  lk_peer;
  logic                   lk_bypass;
  logic                   out_valid;
  logic                   out_ready;
  logic                   out_hit;
  logic [ROUTE_IDX_W-1:0] out_route_idx;
  logic [DPE_PORT_W-1:0]  out_dst;
  logic [DPE_PEER_W-1:0]  out_peer;
  logic                   out_bypass;
  logic                   out_hairpin;
  logic [TAG_W-1:0]       out_tag;
  modport slave (
    input  in_valid, in_dst_ip, in_ingress, in_tag,
    input  lk_hit, lk_route_idx, lk_dst, lk_peer, lk_bypass,
    input  out_ready,
    output in_ready, lk_req_ip, lk_req_valid,
    output out_valid, out_hit, out_route_idx, out_dst, out_peer, out_bypass, out_hairpin, out_tag
  );
  modport master (
    output in_valid, in_dst_ip, in_ingress, in_tag,
    output lk_hit, lk_route_idx, lk_dst, lk_peer, lk_bypass,
    output out_ready,
    input  in_ready, lk_req_ip, lk_req_valid,
    input  out_valid, out_hit, out_route_idx, out_dst, out_peer, out_bypass, out_hairpin, out_tag
  );
endinterface

// File: rtl/dpe_skid_reg.sv
// dpe_skid_reg: 1-deep valid/ready register stage (in_valid_i/in_ready_o/in_data_i -> out_valid_o/out_ready_i/out_data_o), async reset rst
module dpe_skid_reg #(parameter int W = 8) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);
  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;
  assign in_ready_o  = !valid_q || out_ready_i;
  assign valid_d     = in_ready_o ? in_valid_i : valid_q;
  assign data_d      = (in_ready_o && in_valid_i) ? in_data_i : data_q;
  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end
endmodule

// File: rtl/dpe_route_lookup.sv
// dpe_route_lookup: two-stage route lookup client (clk, rst, bus: in/lk/out streams, cfg_freeze_req/ack; stat_clr/stat_* when DPE_ROUTE_LOOKUP_STATS_EN)
module dpe_route_lookup import dpe_pkg::*; #(
  parameter int ROUTE_IDX_W = DPE_ROUTE_IDX_W,
  parameter int TAG_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  dpe_route_lookup_if.slave   bus,
  input  logic                cfg_freeze_req,
  output logic                cfg_freeze_ack
`ifdef DPE_ROUTE_LOOKUP_STATS_EN
  ,
  input  logic                stat_clr,
  output logic [31:0]         stat_hits,
  output logic [31:0]         stat_misses,
  output logic [31:0]         stat_hairpins
`endif
);
  frz_state_e            state_q, state_d;
  logic                  s1_valid_q, s1_valid_d;
  logic [31:0]           ip_q, ip_d;
  logic [DPE_PORT_W-1:0] ing_q, ing_d;
  logic [TAG_W-1:0]      tag_q, tag_d;
  logic                  s2_ready, accept;
  route_res_t            res, out_res;
  logic [TAG_W-1:0]      out_tag;
  assign bus.in_ready     = !rst && state_q == RUN && (!s1_valid_q || s2_ready);
  assign accept           = bus.in_valid && bus.in_ready;
  assign s1_valid_d       = accept || (s1_valid_q && !s2_ready);
  assign ip_d             = accept ? bus.in_dst_ip : ip_q;
  assign ing_d            = accept ? bus.in_ingress : ing_q;
  assign tag_d            = accept ? bus.in_tag : tag_q;
  assign bus.lk_req_ip    = ip_q;
  assign bus.lk_req_valid = s1_valid_q;
  assign cfg_freeze_ack   = state_q == FROZEN;
  always_comb begin
    state_d = (state_q == RUN)   ? (cfg_freeze_req ? DRAIN : RUN) :
              (state_q == DRAIN) ? (!cfg_freeze_req ? RUN : (!s1_valid_q && !bus.out_valid) ? FROZEN : DRAIN) :
                                   (cfg_freeze_req ? FROZEN : RUN);
  end
  always_comb begin
    res.hit     = bus.lk_hit;
    res.idx     = bus.lk_hit ? DPE_ROUTE_IDX_W'(bus.lk_route_idx) : '0;
    res.dst     = bus.lk_dst;
    res.peer    = bus.lk_peer;
    res.bypass  = bus.lk_bypass;
    res.hairpin = bus.lk_hit && bus.lk_dst == ing_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RUN;
      s1_valid_q <= 1'b0;
      ip_q       <= '0;
      ing_q      <= '0;
      tag_q      <= '0;
    end else begin
      state_q    <= state_d;
      s1_valid_q <= s1_valid_d;
      ip_q       <= ip_d;
      ing_q      <= ing_d;
      tag_q      <= tag_d;
    end
  end
  dpe_skid_reg #(.W($bits(route_res_t) + TAG_W)) u_s2 (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (s1_valid_q),
    .in_ready_o  (s2_ready),
    .in_data_i   ({res, tag_q}),
    .out_valid_o (bus.out_valid),
    .out_ready_i (bus.out_ready),
    .out_data_o  ({out_res, out_tag})
  );
  assign bus.out_hit       = out_res.hit;
  assign bus.out_route_idx = ROUTE_IDX_W'(out_res.idx);
  assign bus.out_dst       = out_res.dst;
  assign bus.out_peer      = out_res.peer;
  assign bus.out_bypass    = out_res.bypass;
  assign bus.out_hairpin   = out_res.hairpin;
  assign bus.out_tag       = out_tag;
`ifdef DPE_ROUTE_LOOKUP_STATS_EN
  logic        xfer;
  logic [31:0] hits_q, hits_d, misses_q, misses_d, hp_q, hp_d;
  assign xfer     = bus.out_valid && bus.out_ready;
  assign hits_d   = stat_clr ? '0 : (xfer && out_res.hit) ? sat_inc(hits_q) : hits_q;
  assign misses_d = stat_clr ? '0 : (xfer && !out_res.hit) ? sat_inc(misses_q) : misses_q;
  assign hp_d     = stat_clr ? '0 : (xfer && out_res.hairpin) ? sat_inc(hp_q) : hp_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hits_q   <= '0;
      misses_q <= '0;
      hp_q     <= '0;
    end else begin
      hits_q   <= hits_d;
      misses_q <= misses_d;
      hp_q     <= hp_d;
    end
  end
  assign stat_hits     = hits_q;
  assign stat_misses   = misses_q;
  assign stat_hairpins = hp_q;
`endif
endmodule

// File: tb/tb_dpe_route_lookup.sv
// tb_dpe_route_lookup: directed table-driven bench with a small routing-memory model and freeze/stall/reset sequences
module tb_dpe_route_lookup;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cfg_freeze_req = 1'b0;
  logic cfg_freeze_ack;
  int n_cmp = 0;
  int n_err = 0;
  dpe_route_lookup_if #(.ROUTE_IDX_W(6), .TAG_W(8)) bus ();
  dpe_route_lookup #(.ROUTE_IDX_W(6), .TAG_W(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus),
    .cfg_freeze_req (cfg_freeze_req),
    .cfg_freeze_ack (cfg_freeze_ack)
  );
  always #5 clk = ~clk;
  always_comb begin
    bus.lk_hit       = 1'b0;
    bus.lk_route_idx = 6'h3F;
    bus.lk_dst       = 3'd7;
    bus.lk_peer      = 8'hEE;
    bus.lk_bypass    = 1'b1;
    if (bus.lk_req_ip[31:24] == 8'd10) begin
      bus.lk_hit = 1'b1; bus.lk_route_idx = 6'd0; bus.lk_dst = 3'd2; bus.lk_peer = 8'h05; bus.lk_bypass = 1'b0;
    end else if (bus.lk_req_ip[31:20] == 12'hAC1) begin
      bus.lk_hit = 1'b1; bus.lk_route_idx = 6'd3; bus.lk_dst = 3'd1; bus.lk_peer = 8'h09; bus.lk_bypass = 1'b0;
    end else if (bus.lk_req_ip[31:24] == 8'd20) begin
      bus.lk_hit = 1'b1; bus.lk_route_idx = 6'd5; bus.lk_dst = 3'd4; bus.lk_peer = 8'h22; bus.lk_bypass = 1'b1;
    end
  end
  typedef struct {
    logic [31:0] ip;
    logic [2:0]  ing;
    logic [7:0]  tag;
    logic        hit;
    logic [5:0]  idx;
    logic [2:0]  dst;
    logic [7:0]  peer;
    logic        byp;
    logic        hp;
  } vec_t;
  vec_t vt[6];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask
  task automatic send_one(input vec_t v);
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_dst_ip = v.ip; bus.in_ingress = v.ing; bus.in_tag = v.tag;
    #1 chk("accept_ready", bus.in_ready, 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    chk("lk_req_valid", bus.lk_req_valid, 1);
    chk("lk_req_ip", bus.lk_req_ip, v.ip);
    chk("lat_early", bus.out_valid, 0);
    @(negedge clk);
    #1;
    chk("out_valid", bus.out_valid, 1);
    chk("out_hit", bus.out_hit, v.hit);
    chk("out_idx", bus.out_route_idx, v.idx);
    chk("out_dst", bus.out_dst, v.dst);
    chk("out_peer", bus.out_peer, v.peer);
    chk("out_bypass", bus.out_bypass, v.byp);
    chk("out_hairpin", bus.out_hairpin, v.hp);
    chk("out_tag", bus.out_tag, v.tag);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int rx, tx;
    logic hold, got_ack;
    logic [7:0] held;
    vt[0] = '{32'h0A010203, 3'd1, 8'h11, 1'b1, 6'd0, 3'd2, 8'h05, 1'b0, 1'b0};
    vt[1] = '{32'hC0A80001, 3'd7, 8'h22, 1'b0, 6'd0, 3'd7, 8'hEE, 1'b1, 1'b0};
    vt[2] = '{32'hAC100505, 3'd1, 8'h33, 1'b1, 6'd3, 3'd1, 8'h09, 1'b0, 1'b1};
    vt[3] = '{32'h14090909, 3'd0, 8'h44, 1'b1, 6'd5, 3'd4, 8'h22, 1'b1, 1'b0};
    vt[4] = '{32'h0AFF0001, 3'd2, 8'h55, 1'b1, 6'd0, 3'd2, 8'h05, 1'b0, 1'b1};
    vt[5] = '{32'hAC200001, 3'd3, 8'h66, 1'b0, 6'd0, 3'd7, 8'hEE, 1'b1, 1'b0};
    bus.in_valid = 1'b0; bus.in_dst_ip = '0; bus.in_ingress = '0; bus.in_tag = '0; bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_ack", cfg_freeze_ack, 0);
    chk("rst_lk_valid", bus.lk_req_valid, 0);
    chk("rst_lk_ip", bus.lk_req_ip, 0);
    chk("rst_out_tag", bus.out_tag, 0);
    chk("rst_out_peer", bus.out_peer, 0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("run_after_rst", bus.in_ready, 1);
    for (int i = 0; i < 6; i++) send_one(vt[i]);
    tx = 0; rx = 0; hold = 1'b0; held = '0;
    for (int c = 0; c < 60 && rx < 8; c++) begin
      @(negedge clk);
      bus.out_ready = !(c >= 4 && c < 9);
      bus.in_valid = tx < 8; bus.in_tag = 8'h40 + 8'(tx); bus.in_dst_ip = 32'h0A000000 + tx; bus.in_ingress = 3'd3;
      #1;
      if (hold) begin
        chk("stall_valid", bus.out_valid, 1);
        chk("stall_tag", bus.out_tag, held);
      end
      if (bus.out_valid && bus.out_ready) begin
        chk("b2b_order", bus.out_tag, 8'h40 + 8'(rx));
        rx++;
      end
      hold = bus.out_valid && !bus.out_ready;
      held = bus.out_tag;
      if (bus.in_valid && bus.in_ready) tx++;
    end
    chk("b2b_rx", rx, 8);
    @(negedge clk);
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    #1 chk("b2b_no_dup", bus.out_valid, 0);
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_tag = 8'h71; bus.in_dst_ip = 32'h0A000001; bus.in_ingress = 3'd0;
    #1 chk("frz_a_ready", bus.in_ready, 1);
    @(negedge clk);
    bus.in_tag = 8'h72; bus.in_dst_ip = 32'hAC100001; cfg_freeze_req = 1'b1;
    #1 chk("frz_same_cyc_ready", bus.in_ready, 1);
    rx = 0; got_ack = 1'b0;
    for (int c = 0; c < 20 && !got_ack; c++) begin
      @(negedge clk);
      bus.in_tag = 8'h73; bus.in_dst_ip = 32'h14000001;
      #1;
      chk("frz_in_ready", bus.in_ready, 0);
      if (bus.out_valid && bus.out_ready) begin
        chk("frz_tag", bus.out_tag, 8'h71 + 8'(rx));
        rx++;
      end
      if (cfg_freeze_ack) begin
        chk("frz_ack_after_drain", rx, 2);
        got_ack = 1'b1;
      end
    end
    chk("frz_got_ack", got_ack, 1);
    @(negedge clk);
    bus.in_valid = 1'b0; cfg_freeze_req = 1'b0;
    @(negedge clk);
    #1;
    chk("unfrz_ack", cfg_freeze_ack, 0);
    chk("unfrz_ready", bus.in_ready, 1);
    @(negedge clk);
    cfg_freeze_req = 1'b1;
    @(negedge clk);
    #1;
    chk("frz_empty_c1_ack", cfg_freeze_ack, 0);
    chk("frz_empty_c1_ready", bus.in_ready, 0);
    @(negedge clk);
    #1 chk("frz_empty_c2_ack", cfg_freeze_ack, 1);
    cfg_freeze_req = 1'b0;
    @(negedge clk);
    #1 chk("frz_empty_release", bus.in_ready, 1);
    @(negedge clk);
    cfg_freeze_req = 1'b1;
    @(negedge clk);
    cfg_freeze_req = 1'b0;
    #1;
    chk("abort_drain_ready", bus.in_ready, 0);
    chk("abort_drain_ack", cfg_freeze_ack, 0);
    @(negedge clk);
    #1;
    chk("abort_run_ack", cfg_freeze_ack, 0);
    chk("abort_run_ready", bus.in_ready, 1);
    bus.out_ready = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_tag = 8'h81; bus.in_dst_ip = 32'h0A000002;
    @(negedge clk);
    bus.in_tag = 8'h82;
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    chk("pre_rst_out_valid", bus.out_valid, 1);
    chk("pre_rst_s1_valid", bus.lk_req_valid, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", bus.out_valid, 0);
    chk("mid_rst_lk_valid", bus.lk_req_valid, 0);
    chk("mid_rst_ready", bus.in_ready, 0);
    chk("mid_rst_tag", bus.out_tag, 0);
    @(negedge clk);
    rst = 1'b0; bus.out_ready = 1'b1;
    #1;
    chk("post_rst_ready", bus.in_ready, 1);
    chk("post_rst_out_valid", bus.out_valid, 0);
    send_one(vt[2]);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
